pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It produces the per-stage enables and flushes for PC/IF-ID/ID-EX/EX-MEM/MEM-WB from three inputs: load-use hazards detected between ID and EX, control redirects resolved in EX, and ready handshakes from the instruction and data memories. It tracks data-memory wait with a small FSM, flags wait timeouts, and keeps stall/flush performance counters. It sits beside the ID-stage decoder and consumes the decoder's MemRead/RegWrite outputs as registered in ID/EX.

## Interface
Parameters:
- CNT_W, 16, width of performance counters
- MEM_TIMEOUT, 255, max consecutive data-memory wait cycles before mem_err

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_rs1_used, id_rs2_used  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination of instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved taken branch, jal or jalr
- imem_ready  in  1  instruction fetch data valid this cycle
- mem_req  in  1  MEM stage has a load/store outstanding
- mem_ready  in  1  data memory completes access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables
- ifid_flush, idex_flush, memwb_bubble  out  1 each  insert NOP into that stage register
- mem_err  out  1  sticky data-memory timeout
- stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters

## Operation
- Conditions, evaluated each cycle:
  - memwait = mem_req & ~mem_ready
  - lduse = ex_memread & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd))
  - ifwait = ~imem_ready
- Priority is strict: memwait > ex_redirect > lduse > ifwait > normal.
- memwait freezes everything: all *_en = 0 except memwb_en = 1 with memwb_bubble = 1. No flushes are applied, so a pending redirect stays held in EX and takes effect on the release cycle.
- ex_redirect: pc_en = 1 to load the target, ifid_flush = 1, idex_flush = 1, other enables 1.
- lduse: pc_en = 0, ifid_en = 0, idex_flush = 1 (one bubble), EX/MEM/WB advance.
- ifwait: pc_en = 0, ifid_flush = 1, downstream stages advance.
- normal: all enables 1, no flush or bubble.
- FSM states RUN and MEM_WAIT:
  - RUN → MEM_WAIT when memwait.
  - MEM_WAIT → RUN when mem_ready or mem_req drops.
  - Stage outputs are combinational from the conditions above. The FSM drives only wait_cnt.
- wait_cnt is cleared in RUN and increments in MEM_WAIT. When wait_cnt reaches MEM_TIMEOUT, mem_err is set and stays set until rst. The freeze continues regardless.
- stall_cnt increments each cycle with memwait, lduse or ifwait. flush_cnt increments each cycle with ex_redirect that is not masked by memwait. Both counters saturate at all-ones.

## Timing
- Stage controls: zero latency, combinational from the current inputs.
- State, wait_cnt, counters and mem_err: update on the clock edge after the condition.
- While rst = 1: all *_en = 0, ifid_flush = idex_flush = memwb_bubble = 1, mem_err = 0, counters = 0, state = RUN.
- Reset asserted mid-wait aborts the wait immediately. The first cycle after release behaves as RUN.
- A load-use hazard costs exactly 1 stall cycle. On the next cycle the load is in MEM and the hazard condition is false.
- A redirect costs exactly 2 flushed slots.
- A redirect held through memwait flushes on the first cycle with mem_ready = 1, and flush_cnt increments once.
- A load-use hazard during memwait is deferred. No double bubble is inserted.

## Structure
- Add FSM state encodings HZ_RUN/HZ_MEM_WAIT to def.v alongside the existing ALUOp/WDSel defines.
- One sub-module: sat_counter (parameter W; ports clk, rst, inc, q), instantiated twice for the performance counters.

## Test plan
- lw x5 in EX (ex_memread = 1, ex_rd = 5), ID has id_rs1 = 5 used → pc_en = 0, ifid_en = 0, idex_flush = 1 for 1 cycle; stall_cnt = 1.
- Same as above but ex_rd = 0, or id_rs1_used = 0 → normal flow, no stall.
- ex_redirect = 1 together with an active load-use condition → ifid_flush = idex_flush = 1, pc_en = 1; flush_cnt = 1, stall_cnt unchanged.
- mem_req = 1, mem_ready = 0 for 3 cycles with ex_redirect = 1 → all stages frozen and memwb_bubble = 1 for 3 cycles; flush applied on the 4th cycle; stall_cnt = 3, flush_cnt = 1.
- MEM_TIMEOUT = 4, mem_ready held low → mem_err rises after 4 cycles in MEM_WAIT and stays high after mem_ready; cleared only by rst.
- rst pulsed during MEM_WAIT → outputs go to reset values asynchronously, counters = 0, next cycle is normal flow.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: wait FSM states, the per-cycle
// action chosen by priority, and the stage control bundle each action maps to.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  typedef enum logic [2:0] {
    ActNormal,
    ActIfWait,
    ActLdUse,
    ActRedirect,
    ActMemWait,
    ActReset
  } hz_action_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } stage_ctrl_t;

  function automatic stage_ctrl_t stage_ctrl(input hz_action_e act);
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
          ifid_flush: 1'b0, idex_flush: 1'b0, memwb_bubble: 1'b0};
    case (act)
      ActIfWait: begin
        c.pc_en      = 1'b0;
        c.ifid_flush = 1'b1;
      end
      ActLdUse: begin
        c.pc_en      = 1'b0;
        c.ifid_en    = 1'b0;
        c.idex_flush = 1'b1;
      end
      ActRedirect: begin
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
      end
      // Only MEM/WB moves, and it takes a bubble so WB never retires twice.
      ActMemWait: begin
        c.pc_en        = 1'b0;
        c.ifid_en      = 1'b0;
        c.idex_en      = 1'b0;
        c.exmem_en     = 1'b0;
        c.memwb_bubble = 1'b1;
      end
      ActReset: begin
        c = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
              ifid_flush: 1'b1, idex_flush: 1'b1, memwb_bubble: 1'b1};
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: per-stage enables/flushes from load-use, redirect and
// memory-ready conditions, plus data-memory wait tracking and stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             imem_ready,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  logic             w_memwait;
  logic             w_lduse;
  logic             w_ifwait;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic [WaitW-1:0] w_wait_inc;
  hz_action_e       w_act;
  stage_ctrl_t      w_ctrl;

  hz_state_e        r_state;
  logic [WaitW-1:0] r_wait_cnt;
  logic             r_mem_err;

  assign w_memwait = mem_req & ~mem_ready;
  assign w_lduse   = ex_memread & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign w_ifwait  = ~imem_ready;

  always_comb begin
    w_act = ActNormal;
    if (rst)              w_act = ActReset;
    else if (w_memwait)   w_act = ActMemWait;
    else if (ex_redirect) w_act = ActRedirect;
    else if (w_lduse)     w_act = ActLdUse;
    else if (w_ifwait)    w_act = ActIfWait;
  end

  assign w_ctrl       = stage_ctrl(w_act);
  assign pc_en        = w_ctrl.pc_en;
  assign ifid_en      = w_ctrl.ifid_en;
  assign idex_en      = w_ctrl.idex_en;
  assign exmem_en     = w_ctrl.exmem_en;
  assign memwb_en     = w_ctrl.memwb_en;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_flush   = w_ctrl.idex_flush;
  assign memwb_bubble = w_ctrl.memwb_bubble;

  // A redirect overrides any load-use/fetch stall, so those cycles count as flushes only.
  assign w_stall_inc = w_memwait | (~ex_redirect & (w_lduse | w_ifwait));
  assign w_flush_inc = ex_redirect & ~w_memwait;

  assign w_wait_inc = r_wait_cnt + WaitW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HZ_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        HZ_RUN: begin
          r_wait_cnt <= '0;
          if (w_memwait) r_state <= HZ_MEM_WAIT;
        end
        HZ_MEM_WAIT: begin
          if (!w_memwait) begin
            r_state    <= HZ_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt != WaitMax) begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == WaitMax) r_mem_err <= 1'b1;
          end
        end
        default: r_state <= HZ_RUN;
      endcase
    end
  end

  assign mem_err = r_mem_err;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_stall_inc),
    .q  (stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(w_flush_inc),
    .q  (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: stage control vectors per condition, counters,
// timeout stickiness and asynchronous reset during a memory wait.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW    = 6;
  localparam int unsigned CntMax  = (1 << CntW) - 1;
  localparam int unsigned Timeout = 4;

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush, memwb_bubble}
  localparam logic [7:0] CtrlNormal   = 8'b11111_000;
  localparam logic [7:0] CtrlMemWait  = 8'b00001_001;
  localparam logic [7:0] CtrlRedirect = 8'b11111_110;
  localparam logic [7:0] CtrlLdUse    = 8'b00111_010;
  localparam logic [7:0] CtrlIfWait   = 8'b01111_100;
  localparam logic [7:0] CtrlReset    = 8'b00000_111;

  logic            clk;
  logic            rst;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [4:0]      ex_rd;
  logic            ex_memread;
  logic            ex_redirect;
  logic            imem_ready;
  logic            mem_req;
  logic            mem_ready;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic            memwb_bubble;
  logic            mem_err;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;

  logic [7:0] ctrl;
  int         n_checks;
  int         n_errors;
  int         exp_stall;
  int         exp_flush;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                 memwb_bubble};

  pipe_hazard_ctrl #(
    .CNT_W      (CntW),
    .MEM_TIMEOUT(Timeout)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .ex_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .memwb_bubble(memwb_bubble),
    .mem_err     (mem_err),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    ex_rd       = 5'd0;
    ex_memread  = 1'b0;
    ex_redirect = 1'b0;
    imem_ready  = 1'b1;
    mem_req     = 1'b0;
    mem_ready   = 1'b0;
  endtask

  // Advance one clock, update the saturating counter model and compare both counters.
  task automatic step(input bit stall_inc, input bit flush_inc);
    @(posedge clk);
    #1;
    if (stall_inc && exp_stall < int'(CntMax)) exp_stall++;
    if (flush_inc && exp_flush < int'(CntMax)) exp_flush++;
    check_eq("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check_eq("flush_cnt", 32'(flush_cnt), 32'(exp_flush));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_stall = 0;
    exp_flush = 0;
    rst       = 1'b1;
    set_idle();
    #3;
    check_eq("reset_ctrl", 32'(ctrl), 32'(CtrlReset));
    check_eq("reset_stall", 32'(stall_cnt), 0);
    check_eq("reset_flush", 32'(flush_cnt), 0);
    check_eq("reset_err", 32'(mem_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    #1 check_eq("idle_normal", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);

    // Load-use on rs1 costs exactly one bubble.
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1 check_eq("lduse_rs1", 32'(ctrl), 32'(CtrlLdUse));
    step(1, 0);
    ex_memread = 1'b0;
    #1 check_eq("lduse_next", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);

    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    #1 check_eq("lduse_rd_zero", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);
    ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0;
    #1 check_eq("lduse_rs1_unused", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);
    id_rs2 = 5'd5; id_rs2_used = 1'b1;
    #1 check_eq("lduse_rs2", 32'(ctrl), 32'(CtrlLdUse));
    step(1, 0);
    id_rs2 = 5'd6;
    #1 check_eq("rs2_differs", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);

    // Redirect beats load-use; counted as a flush, not a stall.
    id_rs2 = 5'd5; ex_redirect = 1'b1;
    #1 check_eq("redirect_over_lduse", 32'(ctrl), 32'(CtrlRedirect));
    step(0, 1);

    // Redirect held through a 3-cycle memory wait, applied on release.
    set_idle();
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("wait_freeze", 32'(ctrl), 32'(CtrlMemWait));
      step(1, 0);
    end
    mem_ready = 1'b1;
    #1 check_eq("redirect_release", 32'(ctrl), 32'(CtrlRedirect));
    step(0, 1);

    // Load-use during a wait is deferred to the release cycle.
    set_idle();
    mem_req = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    #1 check_eq("lduse_in_wait", 32'(ctrl), 32'(CtrlMemWait));
    step(1, 0);
    mem_ready = 1'b1;
    #1 check_eq("lduse_deferred", 32'(ctrl), 32'(CtrlLdUse));
    step(1, 0);
    set_idle();
    #1 check_eq("after_deferred", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);

    // Timeout: err rises after Timeout cycles spent in MEM_WAIT, then sticks.
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0);
    check_eq("err_before_timeout", 32'(mem_err), 0);
    step(1, 0);
    check_eq("err_at_timeout", 32'(mem_err), 1);
    #1 check_eq("frozen_after_err", 32'(ctrl), 32'(CtrlMemWait));
    step(1, 0);
    mem_ready = 1'b1;
    #1 check_eq("ready_releases", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);
    set_idle();
    step(0, 0);
    check_eq("err_sticky", 32'(mem_err), 1);

    // Fetch wait, long enough to saturate the stall counter.
    imem_ready = 1'b0;
    #1 check_eq("ifwait", 32'(ctrl), 32'(CtrlIfWait));
    for (int i = 0; i < 70; i++) step(1, 0);
    check_eq("stall_saturated", 32'(stall_cnt), CntMax);
    imem_ready = 1'b1;

    // Asynchronous reset in the middle of a wait.
    mem_req = 1'b1;
    step(1, 0);
    step(1, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_wait_ctrl", 32'(ctrl), 32'(CtrlReset));
    check_eq("rst_wait_stall", 32'(stall_cnt), 0);
    check_eq("rst_wait_flush", 32'(flush_cnt), 0);
    check_eq("rst_wait_err", 32'(mem_err), 0);
    exp_stall = 0;
    exp_flush = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    mem_req = 1'b0;
    #1 check_eq("post_rst_normal", 32'(ctrl), 32'(CtrlNormal));
    step(0, 0);
    // A fresh wait must start its timeout count from zero.
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 0);
    check_eq("wait_restart_no_err", 32'(mem_err), 0);
    step(1, 0);
    check_eq("wait_restart_err", 32'(mem_err), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
